// File: rtl/regfile_dump_reader_if.sv
// Byte stream from the register-file dump engine to the debug UART transmitter.
// valid/ready handshake: a byte moves on a rising edge where both are high.
interface regfile_dump_reader_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_out,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a wrapping range of register-file addresses through one read port and
// streams each word out as bytes, least-significant byte first.
module regfile_dump_reader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_WIDTH-1:0]     first_addr,
  input  logic [ADDR_WIDTH-1:0]     last_addr,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  regfile_dump_reader_if.master     bs,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur, cur_nxt;
  logic [ADDR_WIDTH-1:0] last, last_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt, shift_dn;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [7:0]            byte_out_q, byte_out_nxt;
  logic                  byte_valid_q, byte_valid_nxt;
  logic                  busy_nxt, done_nxt;
  logic                  hs, last_byte;

  assign bs.byte_out   = byte_out_q;
  assign bs.byte_valid = byte_valid_q;

  assign hs        = byte_valid_q && bs.byte_ready;
  assign last_byte = (idx == IDX_W'(BYTES_PER_WORD - 1));
  assign shift_dn  = shift >> 8;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cur          <= '0;
      last         <= '0;
      rd_addr      <= '0;
      shift        <= '0;
      idx          <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cur          <= cur_nxt;
      last         <= last_nxt;
      rd_addr      <= rd_addr_nxt;
      shift        <= shift_nxt;
      idx          <= idx_nxt;
      byte_out_q   <= byte_out_nxt;
      byte_valid_q <= byte_valid_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  // Next state and next registered outputs; abort overrides everything
  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    last_nxt       = last;
    rd_addr_nxt    = rd_addr;
    shift_nxt      = shift;
    idx_nxt        = idx;
    byte_out_nxt   = byte_out_q;
    byte_valid_nxt = 1'b0;
    done_nxt       = 1'b0;

    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_nxt     = first_addr;
            last_nxt    = last_addr;
            rd_addr_nxt = first_addr;
            state_nxt   = S_FETCH;
          end
        end
        S_FETCH: begin
          shift_nxt      = rd_data;
          idx_nxt        = '0;
          byte_out_nxt   = rd_data[7:0];
          byte_valid_nxt = 1'b1;
          state_nxt      = S_SEND;
        end
        S_SEND: begin
          byte_valid_nxt = 1'b1;
          if (hs) begin
            shift_nxt    = shift_dn;
            idx_nxt      = idx + IDX_W'(1);
            byte_out_nxt = shift_dn[7:0];
            if (last_byte) begin
              byte_valid_nxt = 1'b0;
              if (cur == last) begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
              end else begin
                cur_nxt     = cur + ADDR_WIDTH'(1);
                rd_addr_nxt = cur + ADDR_WIDTH'(1);
                state_nxt   = S_FETCH;
              end
            end
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a register-file model, a byte/address
// scoreboard built from the register contents at start, and literal expectations.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;

  regfile_dump_reader_if bs ();

  regfile_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .bs         (bs),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, write visible only after the edge
  logic [31:0] regs [32];
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  always @(posedge clk) if (we) regs[wa] <= wd;
  assign rd_data = regs[rd_addr];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [7:0] exp_b[$];
  logic [7:0] got_b[$];
  logic [4:0] exp_a[$];
  logic [4:0] got_a[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Expected words = ((last-first) mod 32)+1 registers, bytes LSB first
  task automatic launch(input logic [4:0] f, input logic [4:0] l);
    logic [4:0]  d;
    logic [4:0]  a;
    logic [31:0] w;
    int          n;
    d = l - f;
    n = int'(d) + 1;
    for (int k = 0; k < n; k++) begin
      a = f + 5'(k);
      w = regs[a];
      exp_a.push_back(a);
      for (int b = 0; b < 4; b++) exp_b.push_back(w[8*b +: 8]);
    end
  endtask

  // Compare process: FETCH addresses, accepted bytes, hold stability, done pulse
  logic       hold = 1'b0;
  logic [7:0] held = 8'h00;
  logic       prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      hold      = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy && !bs.byte_valid && !done) begin
        got_a.push_back(rd_addr);
        if (exp_a.size() == 0) fail("rd_addr_unexpected_fetch");
        else chk("rd_addr", 32'(rd_addr), 32'(exp_a.pop_front()));
      end
      if (hold && bs.byte_valid) chk("byte_stable", 32'(bs.byte_out), 32'(held));
      hold = bs.byte_valid && !bs.byte_ready && !abort;
      held = bs.byte_out;
      if (bs.byte_valid && bs.byte_ready && !abort) begin
        got_b.push_back(bs.byte_out);
        if (exp_b.size() == 0) fail("stream_extra_byte");
        else chk("stream_byte", 32'(bs.byte_out), 32'(exp_b.pop_front()));
      end
      if (bs.byte_valid) chk("busy_while_valid", 32'(busy), 32'd1);
      if (done) begin
        done_cnt++;
        chk("done_after_all_bytes", 32'(exp_b.size()), 32'd0);
        chk("done_single_cycle", 32'(prev_done), 32'd0);
      end
      prev_done = done;
    end
  end

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic cmp_bytes(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, 32'(got_b.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < got_b.size(); i++)
      chk(name, 32'(got_b[i]), 32'(e[i]));
  endtask

  task automatic cmp_addrs(input string name, input logic [4:0] e[$]);
    chk({name, "_len"}, 32'(got_a.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < got_a.size(); i++)
      chk(name, 32'(got_a[i]), 32'(e[i]));
  endtask

  // One dump; latencies counted in cycles inclusive of the start cycle
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit toggle,
                          input bit do_wr, input logic [4:0] wra, input logic [31:0] wrd,
                          output int first_lat, output int done_lat, output int fetches);
    launch(f, l);
    got_b.delete();
    got_a.delete();
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (do_wr) begin we = 1'b1; wa = wra; wd = wrd; end
    first_lat = -1;
    done_lat  = -1;
    fetches   = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      we = 1'b0;
      if (toggle) bs.byte_ready = ~bs.byte_ready;
      if (bs.byte_valid && first_lat < 0) first_lat = k + 1;
      if (busy && !bs.byte_valid && !done) fetches++;
      if (done) begin
        done_lat = k + 1;
        break;
      end
    end
    if (done_lat < 0) fail("done_timeout");
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("leftover_bytes", 32'(exp_b.size()), 32'd0);
    chk("leftover_addrs", 32'(exp_a.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, dl, fc, dc0;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    first_addr = '0; last_addr = '0;
    we = 1'b0; wa = '0; wd = '0;
    bs.byte_ready = 1'b1;
    #1;
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_byte_valid", 32'(bs.byte_valid), 32'd0);
    chk("reset_byte_out", 32'(bs.byte_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 32; i++) write_reg(5'(i), 32'h0101_0101 * 32'(i) ^ 32'h5A00_00A5);

    // 1: reset mid-byte, then a clean dump of r5
    write_reg(5'd5, 32'hDEADBEEF);
    launch(5'd5, 5'd5);
    first_addr = 5'd5; last_addr = 5'd5; start = 1'b1;
    bs.byte_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("pre_reset_valid", 32'(bs.byte_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_valid", 32'(bs.byte_valid), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_done", 32'(done), 32'd0);
    chk("async_reset_rd_addr", 32'(rd_addr), 32'd0);
    exp_b.delete(); exp_a.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    bs.byte_ready = 1'b1;
    run_dump(5'd5, 5'd5, 1'b0, 1'b0, 5'd0, 32'd0, fl, dl, fc);
    cmp_bytes("t1_bytes", '{8'hEF, 8'hBE, 8'hAD, 8'hDE});
    chk("t1_done_cycles", 32'(dl), 32'd6);

    // 2: range 1..3 with ready held high
    write_reg(5'd1, 32'h0000_0011);
    write_reg(5'd2, 32'h0000_0022);
    write_reg(5'd3, 32'h0000_0033);
    run_dump(5'd1, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0, fl, dl, fc);
    cmp_bytes("t2_bytes", '{8'h11, 8'h00, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00,
                            8'h33, 8'h00, 8'h00, 8'h00});
    cmp_addrs("t2_addrs", '{5'd1, 5'd2, 5'd3});
    chk("t2_first_valid_edges", 32'(fl), 32'd2);
    chk("t2_done_cycles", 32'(dl), 32'd16);
    chk("t2_gap_fetches", 32'(fc), 32'd2);

    // 3: wrap 31..0, r0 not special-cased
    write_reg(5'd31, 32'h4433_2211);
    write_reg(5'd0, 32'h8877_6655);
    run_dump(5'd31, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, fl, dl, fc);
    cmp_bytes("t3_bytes", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    cmp_addrs("t3_addrs", '{5'd31, 5'd0});
    chk("t3_done_cycles", 32'(dl), 32'd11);

    // 4: ready toggling every cycle
    write_reg(5'd9, 32'h0102_0304);
    bs.byte_ready = 1'b0;
    run_dump(5'd9, 5'd9, 1'b1, 1'b0, 5'd0, 32'd0, fl, dl, fc);
    cmp_bytes("t4_bytes", '{8'h04, 8'h03, 8'h02, 8'h01});
    bs.byte_ready = 1'b1;

    // 5: start ignored while busy, abort after the second byte
    dc0 = done_cnt;
    launch(5'd1, 5'd3);
    got_b.delete(); got_a.delete();
    first_addr = 5'd1; last_addr = 5'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; first_addr = 5'd20; last_addr = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_rd_addr_held", 32'(rd_addr), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_abort_valid", 32'(bs.byte_valid), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    exp_b.delete(); exp_a.delete();
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_done", 32'(done_cnt), 32'(dc0));
    cmp_bytes("t5_bytes", '{8'h11, 8'h00});
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("t5_start_abort_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("t5_still_idle", 32'(busy), 32'd0);

    // 6: write to r7 on its FETCH edge is not visible
    write_reg(5'd7, 32'h1234_5678);
    run_dump(5'd7, 5'd7, 1'b0, 1'b1, 5'd7, 32'hAAAA_0000, fl, dl, fc);
    cmp_bytes("t6_bytes", '{8'h78, 8'h56, 8'h34, 8'h12});
    run_dump(5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 32'd0, fl, dl, fc);
    cmp_bytes("t6_after_write", '{8'h00, 8'h00, 8'hAA, 8'hAA});

    // Full 32-word walk, last = first-1
    run_dump(5'd4, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0, fl, dl, fc);
    chk("full_byte_count", 32'(got_b.size()), 32'd128);
    chk("full_done_cycles", 32'(dl), 32'd161);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
